// File: rtl/ahb_master_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// ahb_master_arbiter_2to1
//
// Two-master AHB-lite bus arbiter. M0 (CPU) and M1 (DMA/debug) each see a
// private AHB-lite slave port. The winning master's address phase passes
// straight through to the system bus in the same cycle. A losing master's
// address phase is captured into hold registers, and the master is stalled
// through Mx_HREADY until the held transfer is granted. HRESP is not
// supported, so every response is OKAY.
//
// Parameters
//   AW        address width
//   ARB_MODE  0 = round-robin between contenders, 1 = fixed priority (M0 wins)
//
// Ports
//   HCLK, HRESETn                clock, asynchronous active-low reset
//   Mx_HADDR/HTRANS/HWRITE/HSIZE master x address phase (x = 0, 1)
//   Mx_HWDATA                    master x write data
//   Mx_HREADY                    master x ready (stall while held or waited)
//   Mx_HRDATA                    read data, broadcast from S_HRDATA
//   S_HADDR/HTRANS/HWRITE/HSIZE  system bus address phase
//   S_HWDATA                     write data, muxed by the data-phase owner
//   S_HREADY, S_HRDATA           system bus ready / read data
//   arb_owner                    master driving the current address phase
//
// Optional feature (macro AHB_ARB_MASTLOCK_EN)
//   Adds M0_HMASTLOCK/M1_HMASTLOCK inputs and an S_HMASTLOCK output. A
//   master that issues a locked transfer keeps the bus until one of its
//   address phases with HMASTLOCK=0 completes. When the macro is undefined
//   these ports do not exist, and only burst locking (SEQ/BUSY) applies.
// ---------------------------------------------------------------------------
module ahb_master_arbiter_2to1 #(
    parameter int AW       = 32,
    parameter int ARB_MODE = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [31:0]   M0_HWDATA,
    output logic          M0_HREADY,
    output logic [31:0]   M0_HRDATA,
    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [31:0]   M1_HWDATA,
    output logic          M1_HREADY,
    output logic [31:0]   M1_HRDATA,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [31:0]   S_HWDATA,
    input  logic          S_HREADY,
    input  logic [31:0]   S_HRDATA,
`ifdef AHB_ARB_MASTLOCK_EN
    input  logic          M0_HMASTLOCK,
    input  logic          M1_HMASTLOCK,
    output logic          S_HMASTLOCK,
`endif
    output logic          arb_owner
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_DATA} state_e;

    // Master-side inputs gathered into arrays so that per-master logic can loop.
    logic [1:0][AW-1:0] m_addr;
    logic [1:0][1:0]    m_trans;
    logic [1:0]         m_write;
    logic [1:0][2:0]    m_size;

    assign m_addr  = {M1_HADDR,  M0_HADDR};
    assign m_trans = {M1_HTRANS, M0_HTRANS};
    assign m_write = {M1_HWRITE, M0_HWRITE};
    assign m_size  = {M1_HSIZE,  M0_HSIZE};

    state_e             state_q [2];
    state_e             state_d [2];
    logic [1:0][AW-1:0] hold_addr_q, hold_addr_d;
    logic [1:0][1:0]    hold_trans_q, hold_trans_d;
    logic [1:0]         hold_write_q, hold_write_d;
    logic [1:0][2:0]    hold_size_q, hold_size_d;

    logic arb_owner_q, arb_owner_d;
    logic data_owner_q, data_owner_d;
    logic last_win_q, last_win_d;

    // Address phase each master presents: held copy while in HOLD, live otherwise.
    logic [1:0][AW-1:0] pres_addr;
    logic [1:0][1:0]    pres_trans;
    logic [1:0]         pres_write;
    logic [1:0][2:0]    pres_size;
    logic [1:0]         m_rdy;
    logic [1:0]         req;

    logic [1:0] owner_trans;
    logic       burst_lock;
    logic       keep;
    logic       contested;
    logic       gnt;

`ifdef AHB_ARB_MASTLOCK_EN
    logic [1:0] m_lock;
    logic [1:0] hold_lock_q, hold_lock_d;
    logic [1:0] pres_lock;
    logic       lock_q, lock_d;

    assign m_lock = {M1_HMASTLOCK, M0_HMASTLOCK};
`endif

    always_comb begin
        m_rdy      = '1;
        req        = '0;
        pres_addr  = m_addr;
        pres_trans = m_trans;
        pres_write = m_write;
        pres_size  = m_size;
`ifdef AHB_ARB_MASTLOCK_EN
        pres_lock  = m_lock;
`endif
        for (int i = 0; i < 2; i++) begin
            unique case (state_q[i])
                ST_HOLD: m_rdy[i] = 1'b0;
                ST_DATA: m_rdy[i] = S_HREADY;
                default: m_rdy[i] = 1'b1;
            endcase
            if (state_q[i] == ST_HOLD) begin
                pres_addr[i]  = hold_addr_q[i];
                pres_trans[i] = hold_trans_q[i];
                pres_write[i] = hold_write_q[i];
                pres_size[i]  = hold_size_q[i];
`ifdef AHB_ARB_MASTLOCK_EN
                pres_lock[i]  = hold_lock_q[i];
`endif
            end
            req[i] = (state_q[i] == ST_HOLD) | (m_rdy[i] & m_trans[i][1]);
        end
    end

    // Arbitration is evaluated every cycle but only committed when S_HREADY=1.
    always_comb begin
        owner_trans = pres_trans[arb_owner_q];
        // An owner in the middle of a burst (SEQ/BUSY) must not be interrupted.
        burst_lock  = (owner_trans == TR_SEQ) || (owner_trans == TR_BUSY);
`ifdef AHB_ARB_MASTLOCK_EN
        keep        = burst_lock | lock_q;
`else
        keep        = burst_lock;
`endif
        contested   = req[0] & req[1];

        if (keep)           gnt = arb_owner_q;
        else if (contested) gnt = (ARB_MODE == 1) ? 1'b0 : ~last_win_q;
        else if (req[0])    gnt = 1'b0;
        else if (req[1])    gnt = 1'b1;
        else                gnt = arb_owner_q;

        arb_owner_d  = arb_owner_q;
        data_owner_d = data_owner_q;
        last_win_d   = last_win_q;
`ifdef AHB_ARB_MASTLOCK_EN
        lock_d       = lock_q;
`endif
        if (S_HREADY) begin
            arb_owner_d  = gnt;
            data_owner_d = gnt;
            // Only a real two-way decision moves the round-robin pointer.
            if (contested && !keep) last_win_d = gnt;
`ifdef AHB_ARB_MASTLOCK_EN
            lock_d       = pres_lock[gnt];
`endif
        end
    end

    // Per-master IDLE/HOLD/DATA next state and hold-register capture.
    always_comb begin
        hold_addr_d  = hold_addr_q;
        hold_trans_d = hold_trans_q;
        hold_write_d = hold_write_q;
        hold_size_d  = hold_size_q;
`ifdef AHB_ARB_MASTLOCK_EN
        hold_lock_d  = hold_lock_q;
`endif
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                ST_HOLD: begin
                    if (S_HREADY && gnt == 1'(i)) state_d[i] = ST_DATA;
                end
                ST_DATA, ST_IDLE: begin
                    // In DATA a new address is only taken once the current data
                    // phase completes. In IDLE the master's HREADY is already high.
                    if (state_q[i] == ST_IDLE || S_HREADY) begin
                        if (!m_trans[i][1]) begin
                            state_d[i] = ST_IDLE;
                        end else if (S_HREADY && gnt == 1'(i)) begin
                            state_d[i] = ST_DATA;
                        end else begin
                            state_d[i]      = ST_HOLD;
                            hold_addr_d[i]  = m_addr[i];
                            hold_trans_d[i] = m_trans[i];
                            hold_write_d[i] = m_write[i];
                            hold_size_d[i]  = m_size[i];
`ifdef AHB_ARB_MASTLOCK_EN
                            hold_lock_d[i]  = m_lock[i];
`endif
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) state_q[i] <= ST_IDLE;
            hold_addr_q  <= '0;
            hold_trans_q <= '0;
            hold_write_q <= '0;
            hold_size_q  <= '0;
            arb_owner_q  <= 1'b0;
            data_owner_q <= 1'b0;
            last_win_q   <= 1'b1;  // M1 counts as the last winner, so M0 goes first
`ifdef AHB_ARB_MASTLOCK_EN
            hold_lock_q  <= '0;
            lock_q       <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 2; i++) state_q[i] <= state_d[i];
            hold_addr_q  <= hold_addr_d;
            hold_trans_q <= hold_trans_d;
            hold_write_q <= hold_write_d;
            hold_size_q  <= hold_size_d;
            arb_owner_q  <= arb_owner_d;
            data_owner_q <= data_owner_d;
            last_win_q   <= last_win_d;
`ifdef AHB_ARB_MASTLOCK_EN
            hold_lock_q  <= hold_lock_d;
            lock_q       <= lock_d;
`endif
        end
    end

    // With no requester, drive IDLE and let the owner's live control signals through.
    assign S_HADDR   = pres_addr[gnt];
    assign S_HWRITE  = pres_write[gnt];
    assign S_HSIZE   = pres_size[gnt];
    assign S_HTRANS  = (req[gnt] | burst_lock) ? pres_trans[gnt] : TR_IDLE;
    assign S_HWDATA  = data_owner_q ? M1_HWDATA : M0_HWDATA;
    assign M0_HREADY = m_rdy[0];
    assign M1_HREADY = m_rdy[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;
    assign arb_owner = gnt;
`ifdef AHB_ARB_MASTLOCK_EN
    assign S_HMASTLOCK = pres_lock[gnt];
`endif

endmodule
